hack_cpu_ctrl: RTL and testbench

Multi-cycle sequencer for the Hack CPU. It fetches instructions, decodes A- and C-instructions, and drives the team's `ALU` block, which is instantiated alongside it as a separate module. It owns the A, D, IR and PC registers and talks to instruction and data memory through request/acknowledge ports. It sits between the memories and the ALU and is the only block that changes architectural state.

---
 rtl/hack_pkg.sv | 27 ++
 rtl/hack_jump_unit.sv | 12 +
 rtl/hack_cpu_ctrl.sv | 136 +++++++++++++
 tb/tb_hack_cpu_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hack_pkg.sv
// Shared types and constants for the Hack CPU sequencer.
package hack_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 15;

  // Instruction register field positions
  localparam int IR_TYPE    = 15;
  localparam int IR_ABIT    = 12;
  localparam int IR_COMP_HI = 11;
  localparam int IR_COMP_LO = 6;
  localparam int IR_DEST_A  = 5;
  localparam int IR_DEST_D  = 4;
  localparam int IR_DEST_M  = 3;
  localparam int IR_JUMP_HI = 2;
  localparam int IR_JUMP_LO = 0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    MREAD  = 3'd3,
    EXEC   = 3'd4,
    WB     = 3'd5
  } state_t;

endpackage

// File: rtl/hack_jump_unit.sv
// Jump condition evaluation from the jump field and the latched ALU flags.
module hack_jump_unit (
  input  logic [2:0] jump,
  input  logic       zr,
  input  logic       ng,
  output logic       taken
);

  // jump[2]=JLT, jump[1]=JEQ, jump[0]=JGT; combinations OR together
  assign taken = (jump[2] & ng) | (jump[1] & zr) | (jump[0] & ~zr & ~ng);

endmodule

// File: rtl/hack_cpu_ctrl.sv
// Multi-cycle Hack CPU sequencer: fetch, decode, optional M read, execute,
// write back. Owns A, D, IR, PC plus the M-read (MR) and result (R) latches.
//
// Handshakes: a requester raises req together with address/we/wdata and holds
// all of them stable until ack is sampled high on a rising edge; req drops the
// cycle after that edge. ack with req low is ignored, and ack may already be
// high in the first req cycle.
module hack_cpu_ctrl
  import hack_pkg::*;
#(
  parameter logic [14:0] RESET_PC = 15'h0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [14:0] instr_addr,
  output logic        instr_req,
  input  logic [15:0] instr_rdata,
  input  logic        instr_ack,
  output logic [14:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_req,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic [15:0] alu_x,
  output logic [15:0] alu_y,
  output logic [5:0]  alu_ctl,
  input  logic [15:0] alu_out,
  input  logic        alu_zr,
  input  logic        alu_ng,
  output logic [14:0] pc,
  output logic [15:0] a_reg,
  output logic [15:0] d_reg,
  output logic [2:0]  fsm_state
);

  state_t              state;
  logic [ADDR_W-1:0]   pc_q;
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   d_q;
  logic [DATA_W-1:0]   ir;
  logic [DATA_W-1:0]   mr;
  logic [DATA_W-1:0]   r;
  logic                zr_q;
  logic                ng_q;
  logic                jump_taken;
  logic [ADDR_W-1:0]   pc_inc;
  logic                wb_write;

  // Natural 15-bit wrap: 7FFF + 1 = 0000
  assign pc_inc   = pc_q + 15'd1;
  assign wb_write = ir[IR_DEST_M];

  hack_jump_unit u_jump (
    .jump  (ir[IR_JUMP_HI:IR_JUMP_LO]),
    .zr    (zr_q),
    .ng    (ng_q),
    .taken (jump_taken)
  );

  // Requests are decoded straight from state so reset removes them at once
  assign instr_req  = (state == FETCH);
  assign mem_req    = (state == MREAD) || ((state == WB) && wb_write);
  assign mem_we     = (state == WB) && wb_write;
  assign instr_addr = pc_q;
  assign mem_addr   = a_q[ADDR_W-1:0];
  assign mem_wdata  = r;

  // ALU operands come straight from registers; only EXEC relies on them
  assign alu_x   = d_q;
  assign alu_y   = ir[IR_ABIT] ? mr : a_q;
  assign alu_ctl = ir[IR_COMP_HI:IR_COMP_LO];

  assign pc        = pc_q;
  assign a_reg     = a_q;
  assign d_reg     = d_q;
  assign fsm_state = state;

  // Sequencer and architectural state; WB uses old A for both jump and M write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      pc_q  <= RESET_PC;
      a_q   <= '0;
      d_q   <= '0;
      ir    <= '0;
      mr    <= '0;
      r     <= '0;
      zr_q  <= 1'b0;
      ng_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: state <= FETCH;
        FETCH: begin
          if (instr_ack) begin
            ir    <= instr_rdata;
            state <= DECODE;
          end
        end
        DECODE: begin
          if (!ir[IR_TYPE]) begin
            a_q   <= {1'b0, ir[14:0]};
            pc_q  <= pc_inc;
            state <= FETCH;
          end else if (ir[IR_ABIT]) begin
            state <= MREAD;
          end else begin
            state <= EXEC;
          end
        end
        MREAD: begin
          if (mem_ack) begin
            mr    <= mem_rdata;
            state <= EXEC;
          end
        end
        EXEC: begin
          r     <= alu_out;
          zr_q  <= alu_zr;
          ng_q  <= alu_ng;
          state <= WB;
        end
        WB: begin
          if (!wb_write || mem_ack) begin
            if (ir[IR_DEST_A]) a_q <= r;
            if (ir[IR_DEST_D]) d_q <= r;
            pc_q  <= jump_taken ? a_q[ADDR_W-1:0] : pc_inc;
            state <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// Bench for hack_cpu_ctrl: behavioural Hack ALU, instruction driver tasks,
// and a data-memory responder that checks transactions against exp_q.
module tb_hack_cpu_ctrl;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;

  logic        clk;
  logic        reset;
  logic [14:0] instr_addr;
  logic        instr_req;
  logic [15:0] instr_rdata;
  logic        instr_ack;
  logic [14:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic        mem_req;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic [15:0] alu_x;
  logic [15:0] alu_y;
  logic [5:0]  alu_ctl;
  logic [15:0] alu_out;
  logic        alu_zr;
  logic        alu_ng;
  logic [14:0] pc;
  logic [15:0] a_reg;
  logic [15:0] d_reg;
  logic [2:0]  fsm_state;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int mem_delay = 0;
  int mem_req_seen = 0;
  logic [15:0] mem_read_data = 16'h0000;
  logic [31:0] exp_q[$];

  hack_cpu_ctrl #(.RESET_PC(15'h0000)) dut (
    .clk        (clk),
    .reset      (reset),
    .instr_addr (instr_addr),
    .instr_req  (instr_req),
    .instr_rdata(instr_rdata),
    .instr_ack  (instr_ack),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_req    (mem_req),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .alu_x      (alu_x),
    .alu_y      (alu_y),
    .alu_ctl    (alu_ctl),
    .alu_out    (alu_out),
    .alu_zr     (alu_zr),
    .alu_ng     (alu_ng),
    .pc         (pc),
    .a_reg      (a_reg),
    .d_reg      (d_reg),
    .fsm_state  (fsm_state)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Hack ALU: ctl = {zx, nx, zy, ny, f, no}
  function automatic logic [15:0] alu_f(input logic [15:0] x, input logic [15:0] y,
                                        input logic [5:0] c);
    logic [15:0] xx;
    logic [15:0] yy;
    logic [15:0] o;
    xx = c[5] ? 16'h0000 : x;
    xx = c[4] ? ~xx : xx;
    yy = c[3] ? 16'h0000 : y;
    yy = c[2] ? ~yy : yy;
    o  = c[1] ? (xx + yy) : (xx & yy);
    o  = c[0] ? ~o : o;
    return o;
  endfunction

  assign alu_out   = alu_f(alu_x, alu_y, alu_ctl);
  assign alu_zr    = (alu_out == 16'h0000);
  assign alu_ng    = alu_out[15];
  assign mem_rdata = mem_read_data;

  function automatic logic [31:0] mem_snapshot();
    return {mem_we, mem_addr, (mem_we ? mem_wdata : 16'h0000)};
  endfunction

  // Data memory responder and scoreboard: checks hold stability, pops on ack
  initial begin : mem_responder
    int wait_cnt;
    logic [31:0] snap;
    logic [31:0] e;
    logic [31:0] got;
    wait_cnt = 0;
    snap = '0;
    mem_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (mem_req === 1'b1) begin
        mem_req_seen++;
        got = mem_snapshot();
        if (wait_cnt == 0) begin
          snap = got;
        end else begin
          total++;
          if (got !== snap) begin
            bad++;
            $display("FAIL mem_hold: got %h required %h", got, snap);
          end
        end
        if (wait_cnt >= mem_delay) begin
          mem_ack = 1'b1;
          wait_cnt = 0;
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL mem_unexpected: got %h required no transaction", got);
          end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
              bad++;
              $display("FAIL mem_txn: got %h required %h", got, e);
            end
          end
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Driver tasks
  task automatic wait_fetch();
    int n;
    n = 0;
    while (instr_req !== 1'b1 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 50) begin
      total++;
      bad++;
      $display("FAIL fetch_timeout: got instr_req=%b required 1", instr_req);
    end
  endtask

  task automatic fetch(input logic [15:0] instr, input int waits);
    wait_fetch();
    repeat (waits) begin
      @(posedge clk);
      #1;
    end
    instr_rdata = instr;
    instr_ack = 1'b1;
    @(posedge clk);
    #1;
    instr_ack = 1'b0;
  endtask

  // Tests
  task automatic test_reset();
    reset = 1'b1;
    instr_ack = 1'b0;
    instr_rdata = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (fsm_state !== ST_IDLE) begin bad++; $display("FAIL rst_state: got %0d required %0d", fsm_state, ST_IDLE); end
    total++;
    if ({instr_req, mem_req, mem_we} !== 3'b000) begin bad++; $display("FAIL rst_req: got %b required 000", {instr_req, mem_req, mem_we}); end
    total++;
    if ({pc, a_reg, d_reg} !== 47'h0) begin bad++; $display("FAIL rst_regs: got pc=%h a=%h d=%h required 0", pc, a_reg, d_reg); end
    mem_req_seen = 0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (fsm_state !== ST_FETCH || instr_req !== 1'b1 || instr_addr !== 15'h0000) begin
      bad++;
      $display("FAIL rst_fetch: got state=%0d req=%b addr=%h required 1/1/0000", fsm_state, instr_req, instr_addr);
    end
    total++;
    if (mem_req_seen !== 0) begin bad++; $display("FAIL rst_no_mem: got %0d required 0", mem_req_seen); end
  endtask

  task automatic test_a_then_d();
    int t0;
    wait_fetch();
    t0 = cyc;
    fetch(16'h0005, 0);
    fetch(16'hEC10, 0);
    wait_fetch();
    total++;
    if (cyc - t0 !== 6) begin bad++; $display("FAIL a_d_cycles: got %0d required 6", cyc - t0); end
    total++;
    if (d_reg !== 16'h0005 || a_reg !== 16'h0005) begin bad++; $display("FAIL a_d_regs: got a=%h d=%h required 0005/0005", a_reg, d_reg); end
    total++;
    if (pc !== 15'd2) begin bad++; $display("FAIL a_d_pc: got %h required 0002", pc); end
  endtask

  task automatic test_mem_write();
    int t0;
    logic [14:0] p;
    fetch(16'h0005, 0);
    fetch(16'hEC10, 0);
    fetch(16'h0010, 1);
    mem_delay = 3;
    exp_q.push_back({1'b1, 15'h0010, 16'h0006});
    wait_fetch();
    t0 = cyc;
    p = pc;
    fetch(16'hE7C8, 0);
    wait_fetch();
    mem_delay = 0;
    total++;
    if (cyc - t0 !== 7) begin bad++; $display("FAIL mwr_cycles: got %0d required 7", cyc - t0); end
    total++;
    if (d_reg !== 16'h0005 || a_reg !== 16'h0010 || pc !== p + 15'd1) begin
      bad++;
      $display("FAIL mwr_regs: got a=%h d=%h pc=%h required 0010/0005/%h", a_reg, d_reg, pc, p + 15'd1);
    end
    total++;
    if (exp_q.size() !== 0) begin bad++; $display("FAIL mwr_count: got %0d pending required 0", exp_q.size()); end
  endtask

  task automatic test_mem_read();
    int t0;
    mem_delay = 0;
    mem_read_data = 16'hBEEF;
    fetch(16'h0020, 0);
    exp_q.push_back({1'b0, 15'h0020, 16'h0000});
    wait_fetch();
    t0 = cyc;
    fetch(16'hFC10, 0);
    wait_fetch();
    total++;
    if (cyc - t0 !== 5) begin bad++; $display("FAIL mrd_cycles: got %0d required 5", cyc - t0); end
    total++;
    if (d_reg !== 16'hBEEF) begin bad++; $display("FAIL mrd_d: got %h required beef", d_reg); end
    total++;
    if (exp_q.size() !== 0) begin bad++; $display("FAIL mrd_count: got %0d pending required 0", exp_q.size()); end
  endtask

  task automatic test_jumps();
    logic [14:0] p;
    fetch(16'h0100, 0);
    fetch(16'hEA87, 0);
    wait_fetch();
    total++;
    if (pc !== 15'h0100 || instr_addr !== 15'h0100) begin bad++; $display("FAIL jmp_uncond: got %h required 0100", pc); end
    fetch(16'h0001, 0);
    fetch(16'hEC10, 0);
    wait_fetch();
    p = pc;
    fetch(16'hE302, $urandom_range(0, 2));
    wait_fetch();
    total++;
    if (pc !== p + 15'd1) begin bad++; $display("FAIL jmp_jeq_not: got %h required %h", pc, p + 15'd1); end
    fetch(16'hE301, 0);
    wait_fetch();
    total++;
    if (pc !== 15'h0001) begin bad++; $display("FAIL jmp_jgt: got %h required 0001", pc); end
    fetch(16'h7FFF, 0);
    fetch(16'hEA87, 0);
    wait_fetch();
    total++;
    if (pc !== 15'h7FFF) begin bad++; $display("FAIL jmp_top: got %h required 7fff", pc); end
    fetch(16'h0123, 0);
    wait_fetch();
    total++;
    if (pc !== 15'h0000 || a_reg !== 16'h0123) begin bad++; $display("FAIL pc_wrap: got pc=%h a=%h required 0000/0123", pc, a_reg); end
  endtask

  task automatic test_back_to_back();
    mem_delay = 0;
    fetch(16'h0200, 0);
    fetch(16'hEC10, 0);
    fetch(16'h0040, 0);
    exp_q.push_back({1'b1, 15'h0040, 16'h0200});
    fetch(16'hE32F, 0);
    wait_fetch();
    total++;
    if (pc !== 15'h0040) begin bad++; $display("FAIL b2b_jump_old_a: got %h required 0040", pc); end
    total++;
    if (a_reg !== 16'h0200 || d_reg !== 16'h0200) begin bad++; $display("FAIL b2b_regs: got a=%h d=%h required 0200/0200", a_reg, d_reg); end
    total++;
    if (exp_q.size() !== 0) begin bad++; $display("FAIL b2b_count: got %0d pending required 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    int n;
    mem_delay = 5;
    fetch(16'h0030, 0);
    fetch(16'hFC10, 0);
    n = 0;
    while (mem_req !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    total++;
    if (n >= 20) begin bad++; $display("FAIL rmid_no_req: got mem_req=%b required 1", mem_req); end
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (mem_req !== 1'b0 || fsm_state !== ST_IDLE) begin
      bad++;
      $display("FAIL rmid_drop: got req=%b state=%0d required 0/%0d", mem_req, fsm_state, ST_IDLE);
    end
    total++;
    if (pc !== 15'h0000 || d_reg !== 16'h0000 || a_reg !== 16'h0000) begin
      bad++;
      $display("FAIL rmid_regs: got pc=%h a=%h d=%h required 0", pc, a_reg, d_reg);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    mem_delay = 0;
    wait_fetch();
    total++;
    if (instr_addr !== 15'h0000) begin bad++; $display("FAIL rmid_restart: got %h required 0000", instr_addr); end
  endtask

  initial begin
    reset = 1'b1;
    instr_ack = 1'b0;
    instr_rdata = 16'h0000;
    test_reset();
    test_a_then_d();
    test_mem_write();
    test_mem_read();
    test_jumps();
    test_back_to_back();
    test_reset_mid();
    total++;
    if (exp_q.size() !== 0) begin bad++; $display("FAIL final_queue: got %0d pending required 0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish required finish");
    $fatal(1, "timeout");
  end

endmodule
